uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 104 ++++++++++
 tb/tb_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter paced by an external baud tick
module uart_tx #(
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clock_edge,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);
    localparam int aw = $clog2(fifo_depth);
    localparam logic [aw:0] full_count = (aw + 1)'(fifo_depth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [fifo_depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic          tx_next;
    logic          push, pop;

    assign data_ready = count != full_count;
    assign push       = data_valid && data_ready;
    assign busy       = (state != IDLE) || (count != '0);

    // FIFO storage; stale entries are harmless because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // FIFO pointers and occupancy; a push and pop together leave occupancy unchanged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
            count <= count + (aw + 1)'(push) - (aw + 1)'(pop);
        end
    end

    // Frame sequencer: every move happens on a baud tick; STOP chains straight into START
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        tx_next      = tx;
        pop          = 1'b0;
        if (clock_edge) begin
            case (state)
                IDLE, STOP: begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
                START: begin
                    tx_next      = shift[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        tx_next      = shift[1];
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Sequencer registers; tx is registered so each level starts the cycle after a tick
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes frames and checks them against queued bytes
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clock_edge = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_ready, tx, busy;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    bit tick_en = 1'b0;
    int tick_period = 4;
    int tick_cnt = 0;

    int phase = 0;
    int tick_idx = 0;
    int last_stop = -100;
    int last_gap = 0;
    int frames = 0;
    logic [7:0] rx = 8'h00;
    logic last_tx = 1'b1;

    uart_tx #(.fifo_depth(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clock_edge(clock_edge),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // free-running baud tick generator, inputs change on the falling edge
    always @(negedge clk) begin
        if (tick_en) begin
            tick_cnt++;
            clock_edge = (tick_cnt >= tick_period);
            if (clock_edge) tick_cnt = 0;
        end
    end

    // line monitor: one level per tick, line must not move between ticks
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            phase = 0;
            exp_q.delete();
            last_stop = -100;
            last_tx = tx;
        end else if (clock_edge) begin
            tick_idx++;
            if (phase == 0) begin
                if (!tx) begin
                    phase = 1;
                    last_gap = tick_idx - last_stop;
                end
            end else if (phase <= 8) begin
                rx[phase-1] = tx;
                phase++;
            end else begin
                check("stop_bit", tx, 1);
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("frame_byte", rx, exp_q.pop_front());
                frames++;
                last_stop = tick_idx;
                phase = 0;
            end
            last_tx = tx;
        end else begin
            check("tx_stable", tx, last_tx);
        end
    end

    task automatic send(input logic [7:0] b, output bit acc);
        data = b;
        data_valid = 1'b1;
        acc = data_ready;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            clock_edge = 1'b1;
            @(negedge clk);
            clock_edge = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic manual();
        tick_en = 1'b0;
        clock_edge = 1'b0;
    endtask

    task automatic auto_ticks(input int p);
        tick_cnt = 0;
        tick_period = p;
        tick_en = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int f0;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_ready", data_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx", tx, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", data_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_tx", tx, 1);

        f0 = frames;
        auto_ticks(4);
        send(8'hA5, acc);
        check("a5_acc", acc, 1);
        check("a5_busy", busy, 1);
        wait_idle("a5");
        check("a5_frames", frames - f0, 1);

        f0 = frames;
        send(8'h00, acc);
        send(8'hFF, acc);
        wait_idle("b2b");
        check("b2b_gap", last_gap, 1);
        check("b2b_frames", frames - f0, 2);

        manual();
        @(negedge clk);
        f0 = frames;
        for (int i = 0; i < 5; i++) begin
            b = 8'(16 + i);
            send(b, acc);
            check("full_acc", acc, i < 4);
        end
        check("full_ready_low", data_ready, 0);
        clock_edge = 1'b1;
        @(negedge clk);
        clock_edge = 1'b0;
        check("full_ready_rise", data_ready, 1);
        auto_ticks(4);
        wait_idle("full");
        check("full_frames", frames - f0, 4);

        manual();
        @(negedge clk);
        f0 = frames;
        send(8'h11, acc);
        send(8'h22, acc);
        pulse(10);
        clock_edge = 1'b1;
        data = 8'h33;
        data_valid = 1'b1;
        acc = data_ready;
        if (acc) exp_q.push_back(8'h33);
        @(negedge clk);
        clock_edge = 1'b0;
        data_valid = 1'b0;
        check("sim_acc", acc, 1);
        for (int i = 0; i < 3; i++) begin
            b = 8'(68 + 17 * i);
            send(b, acc);
            check("sim_fill_acc", acc, 1);
        end
        check("sim_full", data_ready, 0);
        auto_ticks(3);
        wait_idle("sim");
        check("sim_frames", frames - f0, 6);

        manual();
        @(negedge clk);
        send(8'h3C, acc);
        send(8'hAA, acc);
        send(8'hBB, acc);
        pulse(5);
        check("mid_busy", busy, 1);
        check("mid_bit3", tx, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", data_ready, 1);
        reset_n = 1'b1;
        f0 = frames;
        auto_ticks(4);
        repeat (200) @(negedge clk);
        check("mid_no_frames", frames - f0, 0);
        check("mid_still_idle", busy, 0);

        manual();
        @(negedge clk);
        send(8'h55, acc);
        check("align_hold1", tx, 1);
        @(negedge clk);
        check("align_hold2", tx, 1);
        @(negedge clk);
        check("align_hold3", tx, 1);
        clock_edge = 1'b1;
        @(negedge clk);
        clock_edge = 1'b0;
        check("align_start", tx, 0);
        auto_ticks(4);
        wait_idle("align");

        f0 = frames;
        auto_ticks(4);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) tick_period = int'($urandom_range(2, 6));
            if ($urandom_range(0, 7) == 0) begin
                b = 8'($urandom);
                send(b, acc);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle("rand");
        check("rand_some_frames", frames - f0 > 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
